// File: rtl/ball_render.sv
// Overlays the ball onto the 1024x768 pixel stream through a fixed 2-cycle pipeline.
// Define BALL_ROUND_EN for a circular ball; otherwise a (2*RADIUS+1)^2 square is drawn.
module ball_render #(
    parameter int          RADIUS     = 10,
    parameter logic [11:0] BALL_COLOR = 12'hFFF
) (
    input  logic        pclk,
    input  logic        reset,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    input  logic [11:0] ball_x,
    input  logic [11:0] ball_y,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out
);

    logic [11:0] bx_s;
    logic [11:0] by_s;
    logic        vblnk_d;
    logic        shadow_valid;

    logic signed [12:0] dx_1;
    logic signed [12:0] dy_1;
    logic [10:0]        hcount_1;
    logic [10:0]        vcount_1;
    logic               hsync_1;
    logic               vsync_1;
    logic               hblnk_1;
    logic               vblnk_1;
    logic               blank_1;
    logic [11:0]        rgb_1;

    logic in_ball;
    logic hit;

    // Ball position is sampled only on the vblnk rising edge so a frame never tears.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            vblnk_d      <= 1'b0;
            bx_s         <= '0;
            by_s         <= '0;
            shadow_valid <= 1'b0;
        end else begin
            vblnk_d <= vblnk_in;
            if (vblnk_in && !vblnk_d) begin
                bx_s         <= ball_x;
                by_s         <= ball_y;
                shadow_valid <= 1'b1;
            end
        end
    end

    // Offsets are formed at 13 bits so pixels left of / above the centre stay negative.
    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            dx_1     <= '0;
            dy_1     <= '0;
            hcount_1 <= '0;
            vcount_1 <= '0;
            hsync_1  <= 1'b0;
            vsync_1  <= 1'b0;
            hblnk_1  <= 1'b0;
            vblnk_1  <= 1'b0;
            blank_1  <= 1'b0;
            rgb_1    <= '0;
        end else begin
            dx_1     <= $signed({2'b00, hcount_in} - {1'b0, bx_s});
            dy_1     <= $signed({2'b00, vcount_in} - {1'b0, by_s});
            hcount_1 <= hcount_in;
            vcount_1 <= vcount_in;
            hsync_1  <= hsync_in;
            vsync_1  <= vsync_in;
            hblnk_1  <= hblnk_in;
            vblnk_1  <= vblnk_in;
            blank_1  <= hblnk_in | vblnk_in;
            rgb_1    <= rgb_in;
        end
    end

`ifdef BALL_ROUND_EN
    localparam logic signed [26:0] R_SQ = 27'(RADIUS * RADIUS);

    logic signed [25:0] dx_sq;
    logic signed [25:0] dy_sq;
    logic signed [26:0] dist_sq;

    // NOTE: every always_comb output is assigned on all paths, so no latch is inferred.
    always_comb begin
        dx_sq   = 26'(dx_1) * 26'(dx_1);
        dy_sq   = 26'(dy_1) * 26'(dy_1);
        dist_sq = 27'(dx_sq) + 27'(dy_sq);
        in_ball = (dist_sq <= R_SQ);
    end
`else
    localparam logic [12:0] R_LIM = 13'(RADIUS);

    logic [12:0] adx;
    logic [12:0] ady;

    always_comb begin
        adx     = dx_1[12] ? -dx_1 : dx_1;
        ady     = dy_1[12] ? -dy_1 : dy_1;
        in_ball = (adx <= R_LIM) && (ady <= R_LIM);
    end
`endif

    assign hit = shadow_valid && !blank_1 && in_ball;

    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            hcount_out <= '0;
            vcount_out <= '0;
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= '0;
        end else begin
            hcount_out <= hcount_1;
            vcount_out <= vcount_1;
            hsync_out  <= hsync_1;
            vsync_out  <= vsync_1;
            hblnk_out  <= hblnk_1;
            vblnk_out  <= vblnk_1;
            rgb_out    <= hit ? BALL_COLOR : rgb_1;
        end
    end

endmodule

// File: tb/tb_ball_render.sv
// Scoreboard bench for ball_render: directed pixels are pushed with hand-computed colours
// and a negedge monitor compares each output word when its 2-cycle latency has elapsed.
module tb_ball_render;

`ifdef BALL_ROUND_EN
    localparam int ROUND = 1;
`else
    localparam int ROUND = 0;
`endif

    // flag order {hsync, vsync, hblnk, vblnk}
    localparam logic [3:0] F_NONE = 4'b0000;
    localparam logic [3:0] F_HS   = 4'b1000;
    localparam logic [3:0] F_HB   = 4'b0010;
    localparam logic [3:0] F_VB   = 4'b0101;

    logic        pclk = 1'b0;
    logic        reset;
    logic [10:0] hcount_in, vcount_in;
    logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
    logic [11:0] rgb_in, ball_x, ball_y;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [11:0] rgb_out;
    logic [37:0] outs;

    always #5 pclk = ~pclk;

    ball_render dut (
        .pclk(pclk), .reset(reset),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in), .ball_x(ball_x), .ball_y(ball_y),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out),
        .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
        .rgb_out(rgb_out)
    );

    assign outs = {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out};

    typedef struct {
        logic [37:0] exp;
        int          h;
        int          v;
        int          due;
    } sb_t;

    sb_t sb[$];
    int  cyc      = 0;
    int  n_checks = 0;
    int  n_errors = 0;

    always @(posedge pclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [37:0] act, input logic [37:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one pixel now and queue what must appear two edges later.
    task automatic apply(input int h, input int v, input int rgb, input logic [3:0] fl, input int ball);
        sb_t e;
        hcount_in = 11'(h);
        vcount_in = 11'(v);
        {hsync_in, vsync_in, hblnk_in, vblnk_in} = fl;
        rgb_in    = 12'(rgb);
        e.exp = {11'(h), 11'(v), fl, (ball != 0) ? 12'hFFF : 12'(rgb)};
        e.h   = h;
        e.v   = v;
        e.due = cyc + 2;
        sb.push_back(e);
    endtask

    task automatic pix(input int h, input int v, input int rgb, input logic [3:0] fl, input int ball);
        @(posedge pclk);
        #1;
        apply(h, v, rgb, fl, ball);
    endtask

    // Vblank rising edge carrying the new ball position in the same cycle, then a second
    // blank cycle at the new centre while the ball inputs move to a decoy position.
    task automatic new_frame(input int nbx, input int nby);
        @(posedge pclk);
        #1;
        ball_x = 12'(nbx);
        ball_y = 12'(nby);
        apply(0, 770, 12'h5A5, F_VB, 0);
        @(posedge pclk);
        #1;
        ball_x = 12'd900;
        ball_y = 12'd900;
        apply(nbx % 2048, nby % 2048, 12'h5A5, F_VB, 0);
    endtask

    always @(negedge pclk) begin
        sb_t e;
        if (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            if (e.due < cyc) begin
                n_checks++;
                n_errors++;
                $display("FAIL late pix(%0d,%0d): due cycle %0d seen at %0d", e.h, e.v, e.due, cyc);
            end else begin
                check($sformatf("pix(%0d,%0d)", e.h, e.v), outs, e.exp);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        hcount_in = 11'd7;
        vcount_in = 11'd9;
        {hsync_in, vsync_in, hblnk_in, vblnk_in} = 4'b1110;
        rgb_in    = 12'hABC;
        ball_x    = 12'd512;
        ball_y    = 12'd384;
        #1 reset  = 1'b0;
        repeat (5) begin
            @(negedge pclk);
            check("in_reset", outs, 38'd0);
        end

        // Release; pipeline must still show zeros for two samples.
        @(posedge pclk);
        #1;
        reset = 1'b1;
        apply(512, 384, 12'h123, F_NONE, 0);
        @(negedge pclk);
        check("post_release0", outs, 38'd0);
        pix(522, 384, 12'h456, F_NONE, 0);
        @(negedge pclk);
        check("post_release1", outs, 38'd0);
        pix(512, 385, 12'h789, F_NONE, 0);

        // Centred ball.
        new_frame(512, 384);
        pix(512, 384, 12'h000, F_NONE, 1);
        pix(522, 384, 12'h000, F_NONE, 1);
        pix(519, 391, 12'h000, F_NONE, 1);
        pix(520, 392, 12'h000, F_NONE, 1 - ROUND);
        pix(523, 384, 12'h000, F_NONE, 0);
        pix(522, 394, 12'h000, F_NONE, 1 - ROUND);
        pix(512, 374, 12'h000, F_NONE, 1);
        pix(512, 373, 12'h000, F_NONE, 0);
        pix(501, 384, 12'h000, F_NONE, 0);
        pix(502, 384, 12'h000, F_NONE, 1);
        pix(600, 384, 12'h111, F_NONE, 0);
        pix(601, 384, 12'h222, F_HS, 0);
        pix(602, 384, 12'h333, F_NONE, 0);
        pix(512, 384, 12'h777, F_NONE, 1);
        pix(530, 384, 12'h777, F_NONE, 0);
        pix(512, 384, 12'h0A5, F_HB, 0);

        // Mid-frame move is deferred to the next frame.
        new_frame(512, 384);
        pix(512, 100, 12'h0F0, F_NONE, 0);
        ball_y = 12'd100;
        pix(512, 200, 12'h0F0, F_NONE, 0);
        pix(512, 384, 12'h0F0, F_NONE, 1);
        pix(512, 100, 12'h0F0, F_NONE, 0);
        new_frame(512, 100);
        pix(512, 100, 12'h0F0, F_NONE, 1);
        pix(512, 384, 12'h0F0, F_NONE, 0);

        // Top-left clipping.
        new_frame(5, 5);
        pix(0, 0, 12'h00F, F_NONE, 1);
        pix(15, 5, 12'h00F, F_NONE, 1);
        pix(16, 5, 12'h00F, F_NONE, 0);
        pix(0, 13, 12'h00F, F_NONE, 1);
        pix(0, 14, 12'h00F, F_NONE, 1 - ROUND);
        pix(5, 15, 12'h00F, F_NONE, 1);
        pix(5, 16, 12'h00F, F_NONE, 0);
        pix(13, 13, 12'h00F, F_NONE, 1 - ROUND);
        pix(1020, 5, 12'h00F, F_NONE, 0);
        pix(2047, 5, 12'h00F, F_NONE, 0);
        pix(5, 5, 12'h00F, F_HB, 0);

        // Far centre: a 12-bit wrapped offset would land inside the ball.
        new_frame(4090, 4090);
        pix(0, 0, 12'h000, F_NONE, 0);
        pix(5, 5, 12'hABC, F_NONE, 0);

        // Asynchronous reset mid-frame drops the ball until the next vblnk edge.
        new_frame(300, 300);
        pix(300, 300, 12'h321, F_NONE, 1);
        repeat (3) @(posedge pclk);
        #1;
        reset = 1'b0;
        #1;
        check("async_reset", outs, 38'd0);
        @(posedge pclk);
        #1;
        reset = 1'b1;
        pix(300, 300, 12'h321, F_NONE, 0);
        pix(0, 0, 12'h321, F_NONE, 0);
        new_frame(300, 300);
        pix(300, 300, 12'h321, F_NONE, 1);

        repeat (4) @(posedge pclk);
        check("sb_empty", 38'(sb.size()), 38'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ball_render.md
# ball_render

Pixel-pipeline stage that consumes the ball position from the ball motion generators (`y_pos`, and `x_pos` from the matching x generator) and overlays the ball onto the VGA timing/colour stream at 1024×768. It sits between the background/paddle drawing stage and the VGA output register. Ball coordinates are captured once per frame at the start of vertical blanking, so the image does not tear. Timing and colour are delayed through a fixed 2-cycle pipeline.

## Interface
Parameters:
- `RADIUS`, 10: ball radius in pixels. Matches the ±10 bounce margins of the motion generators.
- `BALL_COLOR`, 12'hF_F_F: 4:4:4 RGB colour of ball pixels.

Ports:
- `pclk`  in  1  pixel clock; the only clock.
- `reset`  in  1  asynchronous, active-low reset.
- `hcount_in`  in  11  horizontal pixel counter.
- `vcount_in`  in  11  vertical line counter.
- `hsync_in`  in  1  horizontal sync.
- `vsync_in`  in  1  vertical sync.
- `hblnk_in`  in  1  horizontal blanking.
- `vblnk_in`  in  1  vertical blanking.
- `rgb_in`  in  12  upstream pixel colour.
- `ball_x`  in  12  ball centre X, from the x motion generator.
- `ball_y`  in  12  ball centre Y, from `y_pos` of the y motion generator.
- `hcount_out`, `vcount_out`  out  11  timing delayed by 2 cycles.
- `hsync_out`, `vsync_out`, `hblnk_out`, `vblnk_out`  out  1  delayed by 2 cycles.
- `rgb_out`  out  12  composited colour, aligned with the delayed timing.

## Operation
- **Shadow registers `bx_s`, `by_s`, `shadow_valid`**
  - Rising-edge detect on `vblnk_in` (registered `vblnk_d`).
  - When `vblnk_in`=1 and `vblnk_d`=0, latch `ball_x`/`ball_y` into `bx_s`/`by_s` and set `shadow_valid`=1.
  - Ball inputs are ignored at every other time.
- **Stage 1 (registered)**
  - `dx = {1'b0,hcount_in} - {1'b0,bx_s}` and `dy` likewise, both 13-bit signed.
  - Timing, `rgb_in` and `blank = hblnk_in|vblnk_in` are registered alongside.
- **Stage 2 (registered)**
  - `hit` = `shadow_valid` AND NOT `blank` AND inside-test(`dx`,`dy`).
  - `rgb_out` = `hit` ? `BALL_COLOR` : stage-1 rgb.
  - Timing is forwarded unchanged.
- **Inside-test**
  - Round: `dx*dx + dy*dy <= RADIUS*RADIUS`, with 26-bit squares summed at 27 bits. No truncation; signed squaring.
  - Square (macro off): `|dx| <= RADIUS` AND `|dy| <= RADIUS`.
- **Edge clipping**
  - A ball partially off-screen (e.g. `ball_x`=5) draws only its visible pixels.
  - No wrap-around: negative `dx` never aliases to a large positive value.
- **Blanking**
  - Pixels with `hblnk`/`vblnk` set are passed through unmodified, never ball-coloured.

## Timing
- Latency is exactly 2 `pclk` cycles from every input timing/colour signal to the matching output.
- All outputs are 0 during reset, and for the 2 cycles after release until the pipeline fills. `bx_s`, `by_s`, `vblnk_d` and `shadow_valid` reset to 0.
- No ball is drawn after reset until the first `vblnk` rising edge.
- Position change vs. frame:
  - A `ball_x`/`ball_y` change in mid-frame becomes visible only from the next frame.
  - A change in the same cycle as the `vblnk` rising edge is captured (sampled that cycle).
- Reset asserted mid-frame clears everything asynchronously. The ball reappears only after a subsequent `vblnk` rising edge.
- One pixel per cycle, no stalls, no handshake. Upstream timing is trusted as-is.

## Configuration
- `BALL_ROUND_EN` defined: circular inside-test, as above. The multipliers are instantiated in stage 2.
- `BALL_ROUND_EN` undefined: square (2·`RADIUS`+1)² inside-test with no multipliers. Latency and all other behaviour are identical.

## Test plan
- **Reset, then first frame.** Hold `reset`=0 for 5 cycles, release, then stream frame 0 with `ball_x`=512, `ball_y`=384 before any `vblnk` edge. Required: all outputs 0 during reset; no ball pixels in frame 0 (`rgb_out`==`rgb_in` delayed by 2).
- **Centre ball, round.** `ball_x`=512, `ball_y`=384, `rgb_in`=12'h000, frame after the `vblnk` edge, `BALL_ROUND_EN` defined. Required: (512,384), (522,384) and (519,391) give 12'hFFF (the last because 49+49≤100); (520,392) gives 12'h000 (128>100); (523,384) gives 12'h000.
- **Same as above, macro undefined.** Required: (522,394) gives 12'hFFF; (523,384) gives 12'h000.
- **Mid-frame move.** Change `ball_y` from 384 to 100 at `vcount`=200. Required: the rest of that frame still draws at y=384; the next frame draws at y=100.
- **Left/top clipping.** `ball_x`=5, `ball_y`=5. Required: pixels (0..15, 0..15) inside the radius are ball-coloured; no ball pixels at `hcount`≥1020 or in blanking.
- **Latency check.** Pulse `hsync_in` for one cycle. Required: `hsync_out` pulses exactly 2 cycles later; `rgb_out` stays aligned with the delayed `hcount_out`.
